// File: rtl/jk_cmd_gen_pkg.sv
// Shared types for the j/k command generator: FSM states, command codes,
// and the helpers that map commands to button masks and j/k encodings.
package jk_cmd_gen_pkg;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_DRIVE, ST_GAP} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_SET, CMD_CLR, CMD_TGL} cmd_t;

  localparam int NUM_BTN = 3;
  localparam int BTN_SET = 0;
  localparam int BTN_CLR = 1;
  localparam int BTN_TGL = 2;

  // CLR wins over SET, SET over TGL.
  function automatic cmd_t pick_cmd(input logic [NUM_BTN-1:0] pend);
    if (pend[BTN_CLR]) return CMD_CLR;
    if (pend[BTN_SET]) return CMD_SET;
    if (pend[BTN_TGL]) return CMD_TGL;
    return CMD_NONE;
  endfunction

  function automatic logic [NUM_BTN-1:0] cmd_mask(input cmd_t c);
    logic [NUM_BTN-1:0] m;
    m = '0;
    case (c)
      CMD_SET: m[BTN_SET] = 1'b1;
      CMD_CLR: m[BTN_CLR] = 1'b1;
      CMD_TGL: m[BTN_TGL] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Returns {j, k}.
  function automatic logic [1:0] cmd_jk(input cmd_t c);
    case (c)
      CMD_SET: return 2'b10;
      CMD_CLR: return 2'b01;
      CMD_TGL: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_gen_btn_debounce.sv
// One push-button path: 2-flop synchroniser, stability counter, and a
// one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;
  logic          level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level;
      // Level follows sync only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (sync[1] != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/jk_cmd_gen.sv
// Turns three debounced push-buttons into single j/k command windows for a
// downstream JK flip-flop, and predicts that flip-flop's q.
module jk_cmd_gen
  import jk_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 2,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_set,
  input  logic             btn_clr,
  input  logic             btn_tgl,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             q_model,
  output logic [CNT_W-1:0] cmd_cnt
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic [NUM_BTN-1:0] raw, rise, pend, take;
  state_t             state;
  cmd_t               cmd, next_cmd;
  logic [HW-1:0]      hcnt;
  logic               last;

  assign raw = {btn_tgl, btn_clr, btn_set};

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTN-1:0] (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw),
    .rise (rise)
  );

  assign next_cmd = pick_cmd(pend);
  assign take     = (state == ST_IDLE) ? cmd_mask(next_cmd) : '0;
  // Toggle is a single-cycle window so the flip-flop flips exactly once.
  assign last     = (hcnt == ((cmd == CMD_TGL) ? HW'(1) : HW'(HOLD_CYCLES)));
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      cmd     <= CMD_CLR;
      hcnt    <= '0;
      j       <= 1'b0;
      k       <= 1'b0;
      q_model <= 1'b0;
      cmd_cnt <= '0;
      pend    <= '0;
    end else begin
      // A press arriving while its flag is pending simply merges into it.
      pend <= (pend & ~take) | rise;
      case (state)
        ST_INIT: begin
          if (hcnt == HW'(HOLD_CYCLES)) begin
            {j, k}  <= 2'b00;
            q_model <= 1'b0;
            state   <= ST_GAP;
          end else begin
            {j, k} <= cmd_jk(CMD_CLR);
            hcnt   <= hcnt + HW'(1);
          end
        end
        ST_IDLE: begin
          if (next_cmd != CMD_NONE) begin
            cmd    <= next_cmd;
            {j, k} <= cmd_jk(next_cmd);
            hcnt   <= HW'(1);
            state  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (last) begin
            {j, k}  <= 2'b00;
            state   <= ST_GAP;
            cmd_cnt <= cmd_cnt + CNT_W'(1);
            case (cmd)
              CMD_SET: q_model <= 1'b1;
              CMD_CLR: q_model <= 1'b0;
              CMD_TGL: q_model <= ~q_model;
              default: q_model <= q_model;
            endcase
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: begin
          hcnt  <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_gen.sv
// Bench for jk_cmd_gen: a schedule-level model plus a JK flip-flop behind the DUT.
module tb_jk_cmd_gen;
  localparam int DB   = 4;
  localparam int HOLD = 2;
  localparam int CW   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_set = 1'b0, btn_clr = 1'b0, btn_tgl = 1'b0;
  logic          j, k, busy, q_model;
  logic [CW-1:0] cmd_cnt;

  always #5 clk = ~clk;

  jk_cmd_gen #(.DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .btn_set(btn_set), .btn_clr(btn_clr), .btn_tgl(btn_tgl),
    .j(j), .k(k), .busy(busy), .q_model(q_model), .cmd_cnt(cmd_cnt)
  );

  // Downstream flip-flop; starts at 1 so the power-up clear is observable.
  logic ff_q = 1'b1;
  always @(posedge clk)
    case ({j, k})
      2'b10:   ff_q <= 1'b1;
      2'b01:   ff_q <= 1'b0;
      2'b11:   ff_q <= ~ff_q;
      default: ff_q <= ff_q;
    endcase

  int checks = 0, failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- model: edges, samples and command windows ----------------
  logic [2:0] rh [0:8191];
  logic [2:0] m_lvl, m_rise, m_pend;
  logic [1:0] m_cmd;
  logic       mq, m_init, m_valid = 1'b0;
  int         rst_edge, win_start, win_end, next_latch, mcnt;

  task automatic model_step();
    int n, sel, h;
    logic s;
    logic dis;
    n = cyc;
    rh[n] = {btn_tgl, btn_clr, btn_set};
    if (rst) begin
      rst_edge = n; m_lvl = '0; m_rise = '0; m_pend = '0;
      m_cmd = 2'b01; m_init = 1'b1; mq = 1'b0; mcnt = 0;
      win_start = n + 1; win_end = n + HOLD + 1; next_latch = n + HOLD + 3;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (n >= next_latch && m_pend != 3'b000) begin
        sel = m_pend[1] ? 1 : (m_pend[0] ? 0 : 2);
        m_pend[sel] = 1'b0;
        m_cmd  = (sel == 1) ? 2'b01 : ((sel == 0) ? 2'b10 : 2'b11);
        h      = (sel == 2) ? 1 : HOLD;
        m_init = 1'b0;
        win_start = n; win_end = n + h; next_latch = n + h + 2;
      end
      m_pend = m_pend | m_rise;
      if (n == win_end) begin
        mq = (m_cmd == 2'b10) ? 1'b1 : ((m_cmd == 2'b01) ? 1'b0 : ~mq);
        if (!m_init) mcnt = (mcnt + 1) % (1 << CW);
      end
      // A level flips once the last DB synchronised samples all disagree with it.
      for (int b = 0; b < 3; b++) begin
        dis = 1'b1;
        for (int i = n - 1 - DB; i <= n - 2; i++) begin
          s = (i > rst_edge) ? rh[i][b] : 1'b0;
          if (s == m_lvl[b]) dis = 1'b0;
        end
        m_rise[b] = 1'b0;
        if (dis) begin
          m_lvl[b]  = ~m_lvl[b];
          m_rise[b] = m_lvl[b];
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (cyc < 8192) model_step();
  end

  // ---------------- compare + window monitor ----------------
  logic [1:0] prev_jk = 2'b00;
  logic [1:0] win_codes[$];
  int         win_starts[$];
  int         act_cnt = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      logic [1:0] e_jk;
      logic [4+CW-1:0] got, exp;
      e_jk = (cyc >= win_start && cyc < win_end) ? m_cmd : 2'b00;
      got = {j, k, busy, q_model, cmd_cnt};
      exp = {e_jk, (cyc <= win_end), mq, mcnt[CW-1:0]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL cycle %0d {j,k,busy,q_model,cmd_cnt}: got %b expected %b", cyc, got, exp);
      end
      if (!rst && cyc == win_end) begin
        checks++;
        if (ff_q !== mq) begin
          failures++;
          $display("FAIL cycle %0d ff_q after command: got %b expected %b", cyc, ff_q, mq);
        end
      end
    end
    if ({j, k} != 2'b00) begin
      act_cnt++;
      if (prev_jk == 2'b00) begin
        win_codes.push_back({j, k});
        win_starts.push_back(cyc);
      end
    end
    prev_jk = {j, k};
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mon_clear();
    win_codes.delete();
    win_starts.delete();
    act_cnt = 0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 100) begin
      tick(1);
      t++;
    end
    chk({name, " idle timeout"}, int'(busy), 0);
  endtask

  initial begin
    int press_edge, t;
    int exp_cnt [5];
    exp_cnt = '{1, 2, 3, 0, 1};

    // 1: reset, power-up clear
    tick(2);
    rst = 1'b0;
    mon_clear();
    wait_idle("t1");
    chk("t1 windows", win_codes.size(), 1);
    if (win_codes.size() == 1) chk("t1 code", int'(win_codes[0]), 1);
    chk("t1 active cycles", act_cnt, 2);
    chk("t1 ff_q", int'(ff_q), 0);
    chk("t1 q_model", int'(q_model), 0);
    chk("t1 cmd_cnt", int'(cmd_cnt), 0);

    // 2: clean set press, latency and release
    mon_clear();
    btn_set = 1'b1;
    press_edge = cyc + 1;
    tick(10);
    btn_set = 1'b0;
    tick(30);
    wait_idle("t2");
    chk("t2 windows", win_codes.size(), 1);
    if (win_codes.size() == 1) begin
      chk("t2 code", int'(win_codes[0]), 2);
      chk("t2 latency", win_starts[0] - press_edge, 7);
    end
    chk("t2 active cycles", act_cnt, 2);
    chk("t2 ff_q", int'(ff_q), 1);
    chk("t2 cmd_cnt", int'(cmd_cnt), 1);

    // 3: bounce ignored, then a clean toggle
    mon_clear();
    repeat (3) begin
      btn_tgl = 1'b1; tick(3);
      btn_tgl = 1'b0; tick(3);
    end
    tick(20);
    chk("t3 bounce windows", win_codes.size(), 0);
    btn_tgl = 1'b1; tick(10);
    btn_tgl = 1'b0; tick(20);
    wait_idle("t3");
    chk("t3 windows", win_codes.size(), 1);
    if (win_codes.size() == 1) chk("t3 code", int'(win_codes[0]), 3);
    chk("t3 active cycles", act_cnt, 1);
    chk("t3 ff_q", int'(ff_q), 0);

    // 4: simultaneous presses -> CLR, SET, TGL
    mon_clear();
    btn_set = 1'b1; btn_clr = 1'b1; btn_tgl = 1'b1;
    tick(10);
    btn_set = 1'b0; btn_clr = 1'b0; btn_tgl = 1'b0;
    tick(40);
    wait_idle("t4");
    chk("t4 windows", win_codes.size(), 3);
    if (win_codes.size() == 3) begin
      chk("t4 first", int'(win_codes[0]), 1);
      chk("t4 second", int'(win_codes[1]), 2);
      chk("t4 third", int'(win_codes[2]), 3);
      chk("t4 spacing 1", win_starts[1] - win_starts[0], 4);
      chk("t4 spacing 2", win_starts[2] - win_starts[1], 4);
    end
    chk("t4 ff_q", int'(ff_q), 0);
    chk("t4 cmd_cnt", int'(cmd_cnt), 1);

    // 5: reset during the second cycle of a SET window
    btn_set = 1'b1;
    t = 0;
    while (!j && t < 40) begin
      tick(1);
      t++;
    end
    chk("t5 set started", int'(j), 1);
    tick(1);
    btn_set = 1'b0;
    rst = 1'b1;
    mon_clear();
    tick(1);
    chk("t5 j after rst", int'(j), 0);
    chk("t5 k after rst", int'(k), 0);
    rst = 1'b0;
    wait_idle("t5");
    chk("t5 init windows", win_codes.size(), 1);
    if (win_codes.size() == 1) chk("t5 init code", int'(win_codes[0]), 1);
    chk("t5 cmd_cnt", int'(cmd_cnt), 0);
    chk("t5 ff_q", int'(ff_q), 0);
    chk("t5 q_model", int'(q_model), 0);

    // 6: five toggles walk cmd_cnt through the wrap
    for (int i = 0; i < 5; i++) begin
      btn_tgl = 1'b1; tick(8);
      btn_tgl = 1'b0; tick(15);
      wait_idle("t6");
      chk("t6 cmd_cnt", int'(cmd_cnt), exp_cnt[i]);
      chk("t6 q_model", int'(q_model), (i % 2 == 0) ? 1 : 0);
      chk("t6 ff_q", int'(ff_q), int'(q_model));
    end

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
